// File: rtl/mb_dequant_pkg.sv
// mb_dequant_pkg: shared types and constants for the macroblock dequantizer.
//   state_t    FSM states of mb_dequant (IDLE, WHT_ROW, WHT_COL, EMIT, DONE)
//   BLOCK_SIZE coefficients per 4x4 block
//   COEF_W     signed width of a level, a q factor and an output coefficient
//   MB_W       packed width of one block (BLOCK_SIZE * COEF_W)
//   sat16()    clamp a 32-bit signed value to the 16-bit signed range
package mb_dequant_pkg;

  localparam int BLOCK_SIZE = 16;
  localparam int COEF_W     = 16;
  localparam int MB_W       = BLOCK_SIZE * COEF_W;
  localparam int NUM_Y_BLK  = 16;
  localparam int NUM_UV_BLK = 8;
  localparam logic [4:0] LAST_IDX = 5'd23;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WHT_ROW = 3'd1,
    WHT_COL = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [COEF_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7fff;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/mb_iwht4x4.sv
// mb_iwht4x4: two-stage 4x4 inverse Walsh-Hadamard transform (libwebp TransformWHT).
//   clk, rst_n  clock, async active-low reset
//   row_en      load the vertical-pass result into the 20-bit intermediate registers
//   col_en      run the horizontal pass (+3, >>>3, sat16) and register it
//   din         16 dequantized Y2 DC values, entry j at [16j+:16]
//   dout        16 WHT outputs, entry k is the DC of Y block k
// While col_en is high dout bypasses the output register so the first Y block can be
// loaded in the same cycle the horizontal pass is evaluated.
module mb_iwht4x4
  import mb_dequant_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            row_en,
  input  logic            col_en,
  input  logic [MB_W-1:0] din,
  output logic [MB_W-1:0] dout
);

  logic signed [19:0] tmp_q [BLOCK_SIZE];
  logic signed [19:0] tmp_d [BLOCK_SIZE];
  logic [MB_W-1:0]    col_d;
  logic [MB_W-1:0]    out_q;

  // Vertical pass: column i combines entries i, 4+i, 8+i, 12+i.
  always_comb begin
    logic signed [19:0] x0, x1, x2, x3, a0, a1, a2, a3;
    for (int k = 0; k < BLOCK_SIZE; k++) tmp_d[k] = '0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < 4; i++) begin
      x0 = 20'($signed(din[16*i      +: 16]));
      x1 = 20'($signed(din[16*(4+i)  +: 16]));
      x2 = 20'($signed(din[16*(8+i)  +: 16]));
      x3 = 20'($signed(din[16*(12+i) +: 16]));
      a0 = x0 + x3;
      a1 = x1 + x2;
      a2 = x1 - x2;
      a3 = x0 - x3;
      tmp_d[i]    = a0 + a1;
      tmp_d[8+i]  = a0 - a1;
      tmp_d[4+i]  = a3 + a2;
      tmp_d[12+i] = a3 - a2;
    end
  end

  // Horizontal pass on row i; 22-bit sums hold four 19-bit terms plus rounding.
  always_comb begin
    logic signed [21:0] dc, a0, a1, a2, a3;
    col_d = '0;
    dc = '0; a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < 4; i++) begin
      dc = 22'(tmp_q[4*i]) + 22'sd3;
      a0 = dc + 22'(tmp_q[4*i+3]);
      a1 = 22'(tmp_q[4*i+1]) + 22'(tmp_q[4*i+2]);
      a2 = 22'(tmp_q[4*i+1]) - 22'(tmp_q[4*i+2]);
      a3 = dc - 22'(tmp_q[4*i+3]);
      col_d[16*(4*i+0) +: 16] = sat16(32'(a0 + a1) >>> 3);
      col_d[16*(4*i+1) +: 16] = sat16(32'(a3 + a2) >>> 3);
      col_d[16*(4*i+2) +: 16] = sat16(32'(a0 - a1) >>> 3);
      col_d[16*(4*i+3) +: 16] = sat16(32'(a3 - a2) >>> 3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BLOCK_SIZE; k++) tmp_q[k] <= '0;
      out_q <= '0;
    end else begin
      if (row_en) begin
        for (int k = 0; k < BLOCK_SIZE; k++) tmp_q[k] <= tmp_d[k];
      end
      if (col_en) out_q <= col_d;
    end
  end

  assign dout = col_en ? col_d : out_q;

endmodule

// File: rtl/mb_dequant.sv
// mb_dequant: dequantizes one macroblock of levels into 24 4x4 coefficient blocks
// (16 Y raster, 4 U, 4 V) streamed out over valid/ready; i16 macroblocks get their
// Y DC terms from the inverse WHT of the dequantized Y2 levels.
//   start                1-cycle pulse, captures all MB inputs when IDLE
//   mbtype[0]            1 = i16, 0 = i4; skipped != 0 forces all-zero output
//   dc/ac/uv_levels      packed levels; y1_q/y2_q/uv_q packed dequant factors
//   blk_valid/blk_ready  block handshake; blk_idx 0..23, blk_coef 16 x 16-bit signed
//   blk_nz               (only with MB_DEQUANT_NZ_EN) 1 iff blk_coef has a nonzero entry
//   busy                 high from the cycle after an accepted start to the return to IDLE
//   done                 1-cycle pulse after the final handshake
// Handshake: a block transfers on a rising clk edge with blk_valid & blk_ready; while
// blk_valid is high and blk_ready low, blk_idx/blk_coef hold their values.
module mb_dequant
  import mb_dequant_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   mbtype,
  input  logic [7:0]                   skipped,
  input  logic [MB_W-1:0]              dc_levels,
  input  logic [NUM_Y_BLK*MB_W-1:0]    ac_levels,
  input  logic [NUM_UV_BLK*MB_W-1:0]   uv_levels,
  input  logic [MB_W-1:0]              y1_q,
  input  logic [MB_W-1:0]              y2_q,
  input  logic [MB_W-1:0]              uv_q,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [4:0]                   blk_idx,
  output logic [MB_W-1:0]              blk_coef,
`ifdef MB_DEQUANT_NZ_EN
  output logic                         blk_nz,
`endif
  output logic                         busy,
  output logic                         done
);

  state_t state;

  logic [MB_W-1:0]            dc_r, y1_r, y2_r, uvq_r;
  logic [NUM_Y_BLK*MB_W-1:0]  ac_r;
  logic [NUM_UV_BLK*MB_W-1:0] uv_r;
  logic                       i16_r, skip_r;

  logic                       mbtype_unused;
  assign mbtype_unused = ^mbtype[7:1];

  // In IDLE the first i4 block is built straight from the inputs being captured.
  logic                       in_idle;
  logic [NUM_Y_BLK*MB_W-1:0]  src_ac;
  logic [NUM_UV_BLK*MB_W-1:0] src_uv;
  logic [MB_W-1:0]            src_y1, src_uvq;
  logic                       src_i16, src_skip;

  assign in_idle  = (state == IDLE);
  assign src_ac   = in_idle ? ac_levels : ac_r;
  assign src_uv   = in_idle ? uv_levels : uv_r;
  assign src_y1   = in_idle ? y1_q : y1_r;
  assign src_uvq  = in_idle ? uv_q : uvq_r;
  assign src_i16  = in_idle ? mbtype[0] : i16_r;
  assign src_skip = in_idle ? (skipped != 8'd0) : skip_r;

  logic [MB_W-1:0] dc_dq, wht_out;

  always_comb begin
    dc_dq = '0;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      dc_dq[16*j +: 16] = sat16(32'($signed(dc_r[16*j +: 16])) * 32'($signed(y2_r[16*j +: 16])));
    end
  end

  mb_iwht4x4 u_iwht (
    .clk    (clk),
    .rst_n  (rst_n),
    .row_en (state == WHT_ROW),
    .col_en (state == WHT_COL),
    .din    (dc_dq),
    .dout   (wht_out)
  );

  // Index of the block loaded into blk_coef on the next load: 0 on entry to EMIT,
  // otherwise the successor of the block currently being presented.
  logic [4:0]      load_idx;
  logic            coef_load;
  logic [MB_W-1:0] next_coef;

  assign load_idx  = (state == EMIT) ? blk_idx + 5'd1 : 5'd0;
  assign coef_load = (in_idle && start && !mbtype[0]) || (state == WHT_COL) ||
                     ((state == EMIT) && blk_ready && (blk_idx != LAST_IDX));

  always_comb begin
    logic            is_y;
    logic [MB_W-1:0] lvl_blk, q_blk;
    next_coef = '0;
    is_y      = !load_idx[4];
    lvl_blk   = is_y ? src_ac[{load_idx[3:0], 8'd0} +: MB_W]
                     : src_uv[{load_idx[2:0], 8'd0} +: MB_W];
    q_blk     = is_y ? src_y1 : src_uvq;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      next_coef[16*j +: 16] = sat16(32'($signed(lvl_blk[16*j +: 16])) * 32'($signed(q_blk[16*j +: 16])));
    end
    if (is_y && src_i16) next_coef[15:0] = wht_out[{load_idx[3:0], 4'd0} +: 16];
    if (src_skip) next_coef = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk_valid <= 1'b0;
      blk_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dc_r      <= '0;
      ac_r      <= '0;
      uv_r      <= '0;
      y1_r      <= '0;
      y2_r      <= '0;
      uvq_r     <= '0;
      i16_r     <= 1'b0;
      skip_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dc_r   <= dc_levels;
            ac_r   <= ac_levels;
            uv_r   <= uv_levels;
            y1_r   <= y1_q;
            y2_r   <= y2_q;
            uvq_r  <= uv_q;
            i16_r  <= mbtype[0];
            skip_r <= (skipped != 8'd0);
            busy   <= 1'b1;
            if (mbtype[0]) begin
              state <= WHT_ROW;
            end else begin
              state     <= EMIT;
              blk_valid <= 1'b1;
              blk_idx   <= '0;
            end
          end
        end
        WHT_ROW: state <= WHT_COL;
        WHT_COL: begin
          state     <= EMIT;
          blk_valid <= 1'b1;
          blk_idx   <= '0;
        end
        EMIT: begin
          if (blk_ready) begin
            if (blk_idx == LAST_IDX) begin
              state     <= DONE;
              blk_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              blk_idx <= blk_idx + 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         blk_coef <= '0;
    else if (coef_load) blk_coef <= next_coef;
  end

`ifdef MB_DEQUANT_NZ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         blk_nz <= 1'b0;
    else if (coef_load) blk_nz <= |next_coef;
  end
`endif

endmodule
